led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Sequencer for the 8-bit board LED bank. A programmable prescaler produces pattern ticks, and a RUN/PAUSE/IDLE state machine advances one of four LED patterns on each tick. Mode changes use a load/ack handshake and take effect only on tick boundaries while running. The block replaces the fixed free-running binary LED counter at the top level and is driven by debounced board buttons or a host register interface.

## Interface
- TICK_DIV, 25_000_000: base tick period in clk cycles at speed_sel=0; must satisfy TICK_DIV>>3 >= 2
- LED_W, 8: LED bank width; fixed at 8 for this revision
- CNT_W, $clog2(TICK_DIV): prescaler counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  level; sampled in IDLE, moves the block to RUN
- stop  in  1  level; sampled in RUN or PAUSE, moves the block to IDLE; wins over start and hold
- hold  in  1  level; RUN->PAUSE while high, PAUSE->RUN when low
- speed_sel  in  2  tick period = TICK_DIV >> speed_sel
- mode_sel  in  2  0 binary count, 1 walking-one, 2 ping-pong, 3 blink
- mode_load  in  1  1-cycle request to latch mode_sel
- mode_ack  out  1  1-cycle pulse when the requested mode is applied
- busy  out  1  high when state != IDLE
- tick_o  out  1  1-cycle pulse, asserted in the cycle after each LED advance
- LED  out  8  registered pattern output

## Operation
- States:
  - IDLE: LED=0x00, counter=0.
  - RUN: counter runs; LED advances on each tick.
  - PAUSE: counter and LED frozen.
- Transitions, evaluated each edge in this priority order:
  - stop (in RUN or PAUSE) -> IDLE
  - start (in IDLE) -> RUN
  - hold in RUN -> PAUSE
  - !hold in PAUSE -> RUN
- Entering RUN from IDLE: counter=0 and LED=initial pattern of the active mode.
- Entering RUN from PAUSE: counter resumes from its frozen value.
- Tick: in RUN with counter == period-1, counter->0 and LED advances. Period is recomputed from speed_sel on every counter reload and on entry to RUN, so a speed change mid-period takes effect next period.
- Patterns (initial -> step):
  - mode 0: 0x00; +1 mod 256, 0xFF->0x00
  - mode 1: 0x01; rotate left, 0x80->0x01
  - mode 2: 0x01, direction up; shift in current direction; at 0x80 reverse to down, at 0x01 reverse to up; sequence ...0x40,0x80,0x40...
  - mode 3: 0x00; bitwise invert
- Mode handshake:
  - mode_load stores mode_sel in a pending register and sets pending_valid. A newer load before application overwrites it; only one ack is produced.
  - IDLE or PAUSE: applied on the next edge. active mode=pending, LED=new initial pattern (PAUSE only; IDLE keeps 0x00), counter=0, mode_ack=1.
  - RUN: applied at the next tick edge instead of the normal advance. LED=new initial pattern, mode_ack=1 coincident with tick_o.
  - stop with pending_valid: applied on the same edge as the transition to IDLE, with ack.
  - mode_load in the same cycle as an application edge: the older value is applied and the new one stays pending.
- Reset, asynchronous:
  - state=IDLE, LED=0x00, counter=0, active mode=0, pending_valid=0, direction=up
  - mode_ack=0, tick_o=0, busy=0
  - Reset mid-RUN discards all progress.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- start sampled at edge k: busy=1 and LED=initial from k; first advance at edge k+period; tick_o high during cycle k+period to k+period+1.
- Advance spacing in uninterrupted RUN: exactly period cycles.
- hold high for H cycles delays the next advance by exactly H cycles.
- mode_ack is never asserted in two consecutive cycles.
- Period range: TICK_DIV down to TICK_DIV>>3. Counter width CNT_W suffices for every speed.

## Test plan
Sim uses TICK_DIV=16.
- Reset, then start, mode 0, speed 0 -> LED steps 0x00,0x01,0x02 every 16 cycles; tick_o pulses aligned after each step; busy=1.
- Mode 2, speed 3 (period 2), run 20 ticks -> LED 0x01,0x02...0x80,0x40...0x01,0x02, no repeated endpoint.
- In RUN mode 0, pulse mode_load with mode_sel=1 mid-period -> LED unchanged until the tick edge, then 0x01 with mode_ack and tick_o in the same cycle; next tick gives 0x02.
- hold high for 5 cycles at counter=10 -> next advance occurs at 21 cycles after the previous one; LED is frozen throughout.
- start and stop high together in RUN, then a stop with pending mode 3 -> IDLE, LED=0x00, one mode_ack; the subsequent start gives LED 0x00 then 0xFF.
- Assert reset_n low asynchronously mid-period with LED=0x37 -> all outputs 0 immediately; no tick_o or mode_ack after release.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: programmable tick prescaler plus IDLE/RUN/PAUSE control
// stepping one of four LED patterns, with a load/ack mode-change handshake.
module led_pattern_ctrl #(
   parameter int TICK_DIV = 25_000_000,
   parameter int LED_W    = 8,
   parameter int CNT_W    = $clog2(TICK_DIV)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic [1:0]       speed_sel,
   input  logic [1:0]       mode_sel,
   input  logic             mode_load,
   output logic             mode_ack,
   output logic             busy,
   output logic             tick_o,
   output logic [LED_W-1:0] LED
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      M_BIN   = 2'd0,
      M_WALK  = 2'd1,
      M_PING  = 2'd2,
      M_BLINK = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [LED_W-1:0] LED_BOT = LED_W'(1);
   localparam logic [LED_W-1:0] LED_TOP = LED_W'(1) << (LED_W - 1);

   state_t           r_state;
   mode_t            r_mode;
   mode_t            r_pmode;
   dir_t             r_dir;
   logic             r_pvalid;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_per_m1;
   logic [LED_W-1:0] r_led;
   logic             r_ack;
   logic             r_tick;
   logic             r_busy;

   state_t           w_state_nxt;
   mode_t            w_mode_nxt;
   mode_t            w_pmode_nxt;
   dir_t             w_dir_nxt;
   dir_t             w_step_dir;
   logic             w_pvalid_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_per_nxt;
   logic [CNT_W-1:0] w_per_sel;
   logic [LED_W-1:0] w_led_nxt;
   logic [LED_W-1:0] w_step_led;
   logic             w_ack_nxt;
   logic             w_tick_nxt;
   logic             w_apply;
   logic             w_can_apply;
   logic             w_period_end;

   function automatic logic [LED_W-1:0] f_init(input mode_t m);
      logic [LED_W-1:0] v;
      v = '0;
      if (m == M_WALK || m == M_PING) v = LED_BOT;
      return v;
   endfunction

   assign w_per_sel    = CNT_W'((TICK_DIV >> speed_sel) - 1);
   // An ack in the current cycle blocks the next application so acks never abut.
   assign w_can_apply  = r_pvalid && !r_ack;
   assign w_period_end = (r_cnt == r_per_m1);

   always_comb begin
      w_step_dir = r_dir;
      w_step_led = r_led;
      case (r_mode)
         M_BIN:   w_step_led = r_led + LED_W'(1);
         M_WALK:  w_step_led = {r_led[LED_W-2:0], r_led[LED_W-1]};
         M_PING: begin
            if (r_led == LED_TOP) begin
               w_step_dir = DIR_DOWN;
            end else if (r_led == LED_BOT) begin
               w_step_dir = DIR_UP;
            end
            w_step_led = (w_step_dir == DIR_UP) ? (r_led << 1) : (r_led >> 1);
         end
         M_BLINK: w_step_led = ~r_led;
         default: w_step_led = r_led;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode;
      w_pmode_nxt  = r_pmode;
      w_pvalid_nxt = r_pvalid;
      w_dir_nxt    = r_dir;
      w_cnt_nxt    = r_cnt;
      w_per_nxt    = r_per_m1;
      w_led_nxt    = r_led;
      w_tick_nxt   = 1'b0;
      w_apply      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_led_nxt = '0;
            if (w_can_apply) begin
               w_apply    = 1'b1;
               w_mode_nxt = r_pmode;
            end
            if (start) begin
               w_state_nxt = S_RUN;
               w_per_nxt   = w_per_sel;
               w_led_nxt   = f_init(w_mode_nxt);
               w_dir_nxt   = DIR_UP;
            end
         end

         S_RUN: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_led_nxt   = '0;
               w_dir_nxt   = DIR_UP;
               if (w_can_apply) begin
                  w_apply    = 1'b1;
                  w_mode_nxt = r_pmode;
               end
            end else begin
               // The counter still steps on the edge that enters PAUSE, so a
               // hold of H cycles costs exactly H cycles of progress.
               if (hold) w_state_nxt = S_PAUSE;
               if (w_period_end) begin
                  w_cnt_nxt  = '0;
                  w_per_nxt  = w_per_sel;
                  w_tick_nxt = 1'b1;
                  if (w_can_apply) begin
                     w_apply    = 1'b1;
                     w_mode_nxt = r_pmode;
                     w_led_nxt  = f_init(r_pmode);
                     w_dir_nxt  = DIR_UP;
                  end else begin
                     w_led_nxt = w_step_led;
                     w_dir_nxt = w_step_dir;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end

         S_PAUSE: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_led_nxt   = '0;
               w_dir_nxt   = DIR_UP;
               if (w_can_apply) begin
                  w_apply    = 1'b1;
                  w_mode_nxt = r_pmode;
               end
            end else begin
               if (!hold) w_state_nxt = S_RUN;
               if (w_can_apply) begin
                  w_apply    = 1'b1;
                  w_mode_nxt = r_pmode;
                  w_led_nxt  = f_init(r_pmode);
                  w_dir_nxt  = DIR_UP;
                  w_cnt_nxt  = '0;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_led_nxt   = '0;
         end
      endcase

      w_ack_nxt = w_apply;
      if (w_apply) w_pvalid_nxt = 1'b0;
      // A load on an application edge queues behind the value being applied.
      if (mode_load) begin
         w_pmode_nxt  = mode_t'(mode_sel);
         w_pvalid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_mode   <= M_BIN;
         r_pmode  <= M_BIN;
         r_pvalid <= 1'b0;
         r_dir    <= DIR_UP;
         r_cnt    <= '0;
         r_per_m1 <= '0;
         r_led    <= '0;
         r_ack    <= 1'b0;
         r_tick   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode   <= w_mode_nxt;
         r_pmode  <= w_pmode_nxt;
         r_pvalid <= w_pvalid_nxt;
         r_dir    <= w_dir_nxt;
         r_cnt    <= w_cnt_nxt;
         r_per_m1 <= w_per_nxt;
         r_led    <= w_led_nxt;
         r_ack    <= w_ack_nxt;
         r_tick   <= w_tick_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
      end
   end

   assign mode_ack = r_ack;
   assign busy     = r_busy;
   assign tick_o   = r_tick;
   assign LED      = r_led;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: hand-derived vector table, directed corner
// sequences and random stimulus against a cycle-level reference model.
module tb_led_pattern_ctrl;

   localparam int TD = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, hold = 1'b0, mode_load = 1'b0;
   logic [1:0] speed_sel = 2'd0, mode_sel = 2'd0;
   logic       mode_ack, busy, tick_o;
   logic [7:0] LED;

   int n_cmp = 0;
   int n_err = 0;

   led_pattern_ctrl #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .hold(hold),
      .speed_sel(speed_sel), .mode_sel(mode_sel), .mode_load(mode_load),
      .mode_ack(mode_ack), .busy(busy), .tick_o(tick_o), .LED(LED)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit m_active, m_paused, m_up, m_ack, m_tick;
   int m_phase, m_period, m_mode, m_led;
   int pend_q[$];

   function automatic int first_pattern(input int mode);
      return (mode == 1 || mode == 2) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_active = 0; m_paused = 0; m_up = 1; m_ack = 0; m_tick = 0;
      m_phase = 0; m_period = TD; m_mode = 0; m_led = 0;
      pend_q.delete();
   endtask

   task automatic model_advance();
      case (m_mode)
         0: m_led = (m_led + 1) % 256;
         1: m_led = (m_led == 128) ? 1 : m_led * 2;
         2: begin
            if (m_led == 128) m_up = 0;
            else if (m_led == 1) m_up = 1;
            m_led = m_up ? m_led * 2 : m_led / 2;
         end
         default: m_led = 255 - m_led;
      endcase
   endtask

   task automatic model_step();
      bit can_apply;
      bit ack_n;
      can_apply = (pend_q.size() > 0) && !m_ack;
      ack_n = 0;
      m_tick = 0;
      if (!m_active) begin
         if (can_apply) begin m_mode = pend_q.pop_front(); ack_n = 1; end
         m_phase = 0; m_led = 0;
         if (start) begin
            m_active = 1; m_paused = 0; m_up = 1;
            m_period = TD >> speed_sel;
            m_led = first_pattern(m_mode);
         end
      end else if (stop) begin
         if (can_apply) begin m_mode = pend_q.pop_front(); ack_n = 1; end
         m_active = 0; m_paused = 0; m_phase = 0; m_led = 0; m_up = 1;
      end else if (!m_paused) begin
         if (m_phase == m_period - 1) begin
            m_phase = 0; m_period = TD >> speed_sel; m_tick = 1;
            if (can_apply) begin
               m_mode = pend_q.pop_front(); ack_n = 1;
               m_led = first_pattern(m_mode); m_up = 1;
            end else begin
               model_advance();
            end
         end else begin
            m_phase++;
         end
         if (hold) m_paused = 1;
      end else begin
         if (can_apply) begin
            m_mode = pend_q.pop_front(); ack_n = 1;
            m_led = first_pattern(m_mode); m_up = 1; m_phase = 0;
         end
         if (!hold) m_paused = 0;
      end
      if (mode_load) begin
         pend_q.delete();
         pend_q.push_back(int'(mode_sel));
      end
      m_ack = ack_n;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      logic [10:0] act, exp;
      @(posedge clk);
      #1;
      model_step();
      act = {LED, busy, tick_o, mode_ack};
      exp = {m_led[7:0], m_active, m_tick, m_ack};
      chk("model {LED,busy,tick,ack}", int'(act), int'(exp));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int       n;
      bit       st, sp, hd, ld;
      bit [1:0] spd, msel;
      bit [7:0] led;
      bit       bsy, tck, ack;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int n, input bit st, input bit sp, input bit hd,
                               input bit [1:0] spd, input bit [1:0] msel, input bit ld,
                               input bit [7:0] led, input bit bsy, input bit tck,
                               input bit ack);
      vec_t v;
      v.n = n; v.st = st; v.sp = sp; v.hd = hd; v.spd = spd; v.msel = msel; v.ld = ld;
      v.led = led; v.bsy = bsy; v.tck = tck; v.ack = ack;
      return v;
   endfunction

   bit [7:0] ping_exp [21];
   bit [7:0] frozen;
   int       ack_cnt, waited;
   bit       seen;

   initial begin
      //        n   st sp hd spd msel ld  LED  busy tick ack
      tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(15, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 8'h01, 1, 1, 0));
      tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 0));
      tbl.push_back(mk(15, 0, 0, 0, 0, 0, 0, 8'h02, 1, 1, 0));
      tbl.push_back(mk( 5, 0, 0, 0, 0, 0, 0, 8'h02, 1, 0, 0));
      tbl.push_back(mk( 1, 0, 0, 0, 0, 1, 1, 8'h02, 1, 0, 0));
      tbl.push_back(mk( 9, 0, 0, 0, 0, 1, 0, 8'h02, 1, 0, 0));
      tbl.push_back(mk( 1, 0, 0, 0, 0, 1, 0, 8'h01, 1, 1, 1));
      tbl.push_back(mk(16, 0, 0, 0, 0, 1, 0, 8'h02, 1, 1, 0));

      ping_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04, 8'h08,
                   8'h10, 8'h20, 8'h40};

      model_reset();
      #3;
      chk("reset {LED,busy,tick,ack}", int'({LED, busy, tick_o, mode_ack}), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // table: mode 0 stepping, then mid-period mode change
      foreach (tbl[i]) begin
         start = tbl[i].st; stop = tbl[i].sp; hold = tbl[i].hd;
         speed_sel = tbl[i].spd; mode_sel = tbl[i].msel; mode_load = tbl[i].ld;
         cycles(tbl[i].n);
         chk($sformatf("tbl[%0d] LED", i), int'(LED), int'(tbl[i].led));
         chk($sformatf("tbl[%0d] busy", i), int'(busy), int'(tbl[i].bsy));
         chk($sformatf("tbl[%0d] tick", i), int'(tick_o), int'(tbl[i].tck));
         chk($sformatf("tbl[%0d] ack", i), int'(mode_ack), int'(tbl[i].ack));
      end
      mode_load = 0;

      // ping-pong at period 2
      stop = 1; cycle(); stop = 0;
      mode_sel = 2; mode_load = 1; cycle(); mode_load = 0;
      cycle();
      chk("ping apply ack in IDLE", int'(mode_ack), 1);
      chk("ping IDLE LED", int'(LED), 0);
      speed_sel = 3; start = 1; cycle(); start = 0;
      chk("ping start LED", int'(LED), int'(ping_exp[0]));
      for (int i = 1; i <= 20; i++) begin
         cycles(2);
         chk($sformatf("ping step %0d LED", i), int'(LED), int'(ping_exp[i]));
         chk($sformatf("ping step %0d tick", i), int'(tick_o), 1);
      end

      // hold delays the next advance by exactly the hold length
      stop = 1; cycle(); stop = 0;
      mode_sel = 0; mode_load = 1; cycle(); mode_load = 0;
      cycle();
      speed_sel = 0; start = 1; cycle(); start = 0;
      cycles(16);
      chk("hold pre tick", int'(tick_o), 1);
      frozen = LED;
      cycles(10);
      hold = 1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("hold frozen LED", int'(LED), int'(frozen));
      end
      hold = 0;
      waited = 15; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cycle();
         waited++;
         if (tick_o) seen = 1;
         else chk("hold frozen LED", int'(LED), int'(frozen));
      end
      chk("hold tick seen", int'(seen), 1);
      chk("hold advance spacing", waited, 21);

      // start+stop together, then stop with a pending mode 3
      start = 1; stop = 1; cycle(); start = 0; stop = 0;
      chk("start+stop busy", int'(busy), 0);
      chk("start+stop LED", int'(LED), 0);
      start = 1; cycle(); start = 0;
      cycles(3);
      mode_sel = 3; mode_load = 1; cycle(); mode_load = 0;
      cycles(2);
      ack_cnt = 0;
      stop = 1; cycle(); stop = 0;
      ack_cnt += int'(mode_ack);
      chk("stop-pending busy", int'(busy), 0);
      chk("stop-pending LED", int'(LED), 0);
      for (int i = 0; i < 5; i++) begin cycle(); ack_cnt += int'(mode_ack); end
      chk("stop-pending ack count", ack_cnt, 1);
      start = 1; cycle(); start = 0;
      chk("blink start LED", int'(LED), 8'h00);
      cycles(16);
      chk("blink first LED", int'(LED), 8'hFF);

      // async reset mid-period with LED=0x37
      stop = 1; cycle(); stop = 0;
      mode_sel = 0; mode_load = 1; cycle(); mode_load = 0;
      cycle();
      speed_sel = 3; start = 1; cycle(); start = 0;
      cycles(111);
      chk("pre-reset LED", int'(LED), 8'h37);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset outputs", int'({LED, busy, tick_o, mode_ack}), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("post-reset tick/ack", int'({tick_o, mode_ack}), 0);
      end

      // random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom_range(7) == 0);
         stop      = ($urandom_range(59) == 0);
         if ($urandom_range(11) == 0) hold = ~hold;
         mode_load = ($urandom_range(9) == 0);
         mode_sel  = 2'($urandom_range(3));
         if ($urandom_range(29) == 0) speed_sel = 2'($urandom_range(3));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
